// File: rtl/ps2_key_receiver.sv
// ----------------------------------------------------------------------------
// ps2_key_receiver
//
// Filtered, frame-checked PS/2 keyboard receiver. KCLK/KDAT are synchronised,
// KCLK is glitch-filtered, and 11-bit frames (start, 8 data LSB-first, odd
// parity, stop) are captured on falling edges of the filtered clock. Good
// bytes pass through an E0/F0 prefix decoder that folds the extended and
// break prefixes into one 10-bit event, which is queued in a small
// first-word-fall-through FIFO.
//
// Ports
//   CLK         system clock
//   RESET_N     asynchronous active-low reset
//   KCLK, KDAT  PS/2 pins, asynchronous to CLK
//   EV_DATA     head event {break, extended, scan[7:0]}
//   EV_VALID    FIFO not empty
//   EV_READY    consumer takes the head event when EV_VALID is also high
//   EV_COUNT    number of stored events
//   PARITY_ERR  one-cycle pulse: frame failed the odd-parity check
//   FRAME_ERR   one-cycle pulse: bad stop bit or mid-frame timeout
//   OVERFLOW    sticky: an event was dropped because the FIFO was full
//   CLR_OVF     clears OVERFLOW, wins over a same-cycle set
//
// Frame FSM
//   state  | meaning
//   IDLE   | waiting for a start bit (KDAT=0 on a sample edge)
//   DATA   | shifting in the 8 data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking stop bit and parity, releasing the byte
// ----------------------------------------------------------------------------
module ps2_key_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_AW        = 2
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               KCLK,
    input  logic               KDAT,
    output logic [9:0]         EV_DATA,
    output logic               EV_VALID,
    input  logic               EV_READY,
    output logic [FIFO_AW:0]   EV_COUNT,
    output logic               PARITY_ERR,
    output logic               FRAME_ERR,
    output logic               OVERFLOW,
    input  logic               CLR_OVF
);

    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    // ------------------------------------------------------------------
    // Synchronisers (idle-high bus, so they reset to 1)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] kclk_sync;
    logic [SYNC_STAGES-1:0] kdat_sync;
    logic                   kclk_s;
    logic                   kdat_s;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            kclk_sync <= '1;
            kdat_sync <= '1;
        end else begin
            kclk_sync <= {kclk_sync[SYNC_STAGES-2:0], KCLK};
            kdat_sync <= {kdat_sync[SYNC_STAGES-2:0], KDAT};
        end
    end

    assign kclk_s = kclk_sync[SYNC_STAGES-1];
    assign kdat_s = kdat_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // KCLK glitch filter: the filtered clock only follows the synchronised
    // one after FILTER_LEN consecutive differing samples.
    // ------------------------------------------------------------------
    logic [FILT_W-1:0] filt_cnt;
    logic              kclk_filt;
    logic              kclk_filt_d;
    logic              sample_edge;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            filt_cnt    <= '0;
            kclk_filt   <= 1'b1;
            kclk_filt_d <= 1'b1;
        end else begin
            kclk_filt_d <= kclk_filt;
            if (kclk_s == kclk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                // this sample is the FILTER_LEN-th differing one
                kclk_filt <= kclk_s;
                filt_cnt  <= '0;
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end
    end

    assign sample_edge = kclk_filt_d & ~kclk_filt;

    // ------------------------------------------------------------------
    // Frame FSM, timeout, error pulses and prefix decoder
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic              par_bit;
    logic [TO_W-1:0]   to_cnt;
    logic              ext_flag;
    logic              brk_flag;
    logic [7:0]        byte_q;
    logic              byte_valid;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            byte_q     <= '0;
            byte_valid <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            byte_valid <= 1'b0;

            // Prefix decoding runs one cycle after the stop edge; a parity
            // failure can never coincide with it, so the flag writes below
            // do not collide.
            if (byte_valid) begin
                if (byte_q == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end

            if (state == IDLE) begin
                to_cnt <= '0;
                if (sample_edge && !kdat_s) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
            end else if (sample_edge) begin
                to_cnt <= '0;
                case (state)
                    DATA: begin
                        shift_reg <= {kdat_s, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        par_bit <= kdat_s;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!kdat_s) begin
                            FRAME_ERR <= 1'b1;
                        end else if (^{shift_reg, par_bit} == 1'b0) begin
                            // a corrupted byte may have been the key the
                            // pending prefixes belonged to
                            PARITY_ERR <= 1'b1;
                            ext_flag   <= 1'b0;
                            brk_flag   <= 1'b0;
                        end else begin
                            byte_q     <= shift_reg;
                            byte_valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                // prefix flags survive: the keyboard will resend the byte
                state     <= IDLE;
                FRAME_ERR <= 1'b1;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    logic       push_req;
    logic [9:0] push_data;

    assign push_req  = byte_valid && (byte_q != 8'hE0) && (byte_q != 8'hF0);
    assign push_data = {brk_flag, ext_flag, byte_q};

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               pop;
    logic               push_ok;

    assign full    = (count == (FIFO_AW + 1)'(DEPTH));
    assign pop     = EV_VALID && EV_READY;
    // when full, a same-cycle pop frees the slot being written
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
            if (CLR_OVF) begin
                OVERFLOW <= 1'b0;
            end else if (push_req && full && !pop) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    assign EV_VALID = (count != '0);
    assign EV_COUNT = count;
    assign EV_DATA  = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_key_receiver.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_receiver
//
// Directed bench for ps2_key_receiver. Frames are bit-banged on KCLK/KDAT
// with a slow PS/2-like clock; expected events are hand-computed constants.
// A short TIMEOUT_CYCLES keeps the timeout cases quick.
// ----------------------------------------------------------------------------
module tb_ps2_key_receiver;

    localparam int FL  = 8;
    localparam int TO  = 1000;
    localparam int FAW = 2;

    logic           CLK = 1'b0;
    logic           RESET_N;
    logic           KCLK;
    logic           KDAT;
    logic [9:0]     EV_DATA;
    logic           EV_VALID;
    logic           EV_READY;
    logic [FAW:0]   EV_COUNT;
    logic           PARITY_ERR;
    logic           FRAME_ERR;
    logic           OVERFLOW;
    logic           CLR_OVF;

    int n_checks = 0;
    int n_err    = 0;
    int par_pulses   = 0;
    int frame_pulses = 0;
    int par_base;
    int frame_base;

    ps2_key_receiver #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO),
        .FIFO_AW        (FAW)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .KCLK       (KCLK),
        .KDAT       (KDAT),
        .EV_DATA    (EV_DATA),
        .EV_VALID   (EV_VALID),
        .EV_READY   (EV_READY),
        .EV_COUNT   (EV_COUNT),
        .PARITY_ERR (PARITY_ERR),
        .FRAME_ERR  (FRAME_ERR),
        .OVERFLOW   (OVERFLOW),
        .CLR_OVF    (CLR_OVF)
    );

    always #5 CLK = ~CLK;

    // cycles-high counters, so a stretched pulse shows up as a count > 1
    always @(posedge CLK) begin
        if (PARITY_ERR === 1'b1) par_pulses   <= par_pulses + 1;
        if (FRAME_ERR  === 1'b1) frame_pulses <= frame_pulses + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        KDAT = b;
        repeat (10) @(negedge CLK);
        KCLK = 1'b0;
        repeat (20) @(negedge CLK);
        KCLK = 1'b1;
        repeat (15) @(negedge CLK);
    endtask

    task automatic send_head(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_head(b, bad_par);
        send_bit(1'b1);
        repeat (5) @(negedge CLK);
    endtask

    task automatic glitch();
        KCLK = 1'b0;
        repeat (FL - 1) @(negedge CLK);
        KCLK = 1'b1;
        repeat (20) @(negedge CLK);
    endtask

    task automatic pop_check(input string tag, input logic [9:0] exp);
        check({tag, "_valid"}, 16'(EV_VALID), 16'd1);
        check(tag, 16'(EV_DATA), 16'(exp));
        EV_READY = 1'b1;
        @(negedge CLK);
        EV_READY = 1'b0;
    endtask

    task automatic mark_errs();
        par_base   = par_pulses;
        frame_base = frame_pulses;
    endtask

    initial begin
        RESET_N  = 1'b0;
        KCLK     = 1'b1;
        KDAT     = 1'b1;
        EV_READY = 1'b0;
        CLR_OVF  = 1'b0;
        repeat (3) @(negedge CLK);

        // ---- reset state
        check("rst_valid", 16'(EV_VALID),   16'd0);
        check("rst_count", 16'(EV_COUNT),   16'd0);
        check("rst_data",  16'(EV_DATA),    16'h000);
        check("rst_perr",  16'(PARITY_ERR), 16'd0);
        check("rst_ferr",  16'(FRAME_ERR),  16'd0);
        check("rst_ovf",   16'(OVERFLOW),   16'd0);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);
        mark_errs();

        // ---- single make code 0x1C, with stop-edge latency check
        send_head(8'h1C, 1'b0);
        KDAT = 1'b1;
        repeat (10) @(negedge CLK);
        KCLK = 1'b0;
        // 2 sync + 8 filter cycles to the sample edge, +2 to EV_VALID
        repeat (11) @(negedge CLK);
        check("lat_early", 16'(EV_VALID), 16'd0);
        @(negedge CLK);
        check("lat_valid", 16'(EV_VALID), 16'd1);
        repeat (8) @(negedge CLK);
        KCLK = 1'b1;
        repeat (15) @(negedge CLK);
        check("ev1c_data",  16'(EV_DATA),  16'h01C);
        check("ev1c_count", 16'(EV_COUNT), 16'd1);
        EV_READY = 1'b1;
        @(negedge CLK);
        EV_READY = 1'b0;
        check("pop_count", 16'(EV_COUNT), 16'd0);
        check("pop_valid", 16'(EV_VALID), 16'd0);
        // pop while empty is ignored
        EV_READY = 1'b1;
        @(negedge CLK);
        EV_READY = 1'b0;
        check("empty_pop_count", 16'(EV_COUNT), 16'd0);

        // ---- prefixes: F0 1C, E0 F0 75
        send_frame(8'hF0, 1'b0);
        check("pfx_f0_none", 16'(EV_COUNT), 16'd0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("pfx_count", 16'(EV_COUNT), 16'd2);
        pop_check("pfx_brk", 10'h21C);
        pop_check("pfx_ext_brk", 10'h375);
        check("pfx_drained", 16'(EV_COUNT), 16'd0);
        check("clean_perr", 16'(par_pulses - par_base), 16'd0);
        check("clean_ferr", 16'(frame_pulses - frame_base), 16'd0);

        // ---- parity error drops byte and clears pending prefixes
        mark_errs();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b1);
        check("perr_pulse", 16'(par_pulses - par_base), 16'd1);
        check("perr_noferr", 16'(frame_pulses - frame_base), 16'd0);
        check("perr_noev", 16'(EV_COUNT), 16'd0);
        send_frame(8'h1C, 1'b0);
        pop_check("perr_flags_clr", 10'h01C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        pop_check("perr_recover", 10'h21C);

        // ---- timeout mid-frame
        mark_errs();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TO + 50) @(negedge CLK);
        check("to_ferr", 16'(frame_pulses - frame_base), 16'd1);
        check("to_noperr", 16'(par_pulses - par_base), 16'd0);
        check("to_noev", 16'(EV_COUNT), 16'd0);
        send_frame(8'h16, 1'b0);
        pop_check("to_recover", 10'h016);
        // prefix flags survive a timeout
        send_frame(8'hE0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        repeat (TO + 50) @(negedge CLK);
        check("to2_ferr", 16'(frame_pulses - frame_base), 16'd2);
        send_frame(8'h16, 1'b0);
        pop_check("to_keep_ext", 10'h116);

        // ---- overflow
        send_frame(8'h16, 1'b0);
        send_frame(8'h1E, 1'b0);
        send_frame(8'h26, 1'b0);
        send_frame(8'h25, 1'b0);
        check("full_noovf", 16'(OVERFLOW), 16'd0);
        send_frame(8'h2E, 1'b0);
        send_frame(8'h36, 1'b0);
        check("ovf_count", 16'(EV_COUNT), 16'd4);
        check("ovf_flag",  16'(OVERFLOW), 16'd1);
        pop_check("drain0", 10'h016);
        pop_check("drain1", 10'h01E);
        pop_check("drain2", 10'h026);
        pop_check("drain3", 10'h025);
        check("drain_count", 16'(EV_COUNT), 16'd0);
        check("ovf_sticky",  16'(OVERFLOW), 16'd1);
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        check("ovf_clear", 16'(OVERFLOW), 16'd0);

        // ---- glitch rejection, idle and mid-frame
        mark_errs();
        KDAT = 1'b0;
        repeat (5) @(negedge CLK);
        glitch();
        KDAT = 1'b1;
        send_frame(8'h1C, 1'b0);
        check("glitch_idle_count", 16'(EV_COUNT), 16'd1);
        pop_check("glitch_idle", 10'h01C);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        glitch();
        for (int i = 3; i < 8; i++) send_bit(8'h26 >> i);
        send_bit(~^8'h26);
        send_bit(1'b1);
        repeat (5) @(negedge CLK);
        check("glitch_mid_count", 16'(EV_COUNT), 16'd1);
        pop_check("glitch_mid", 10'h026);
        check("glitch_perr", 16'(par_pulses - par_base), 16'd0);
        check("glitch_ferr", 16'(frame_pulses - frame_base), 16'd0);

        // ---- reset mid-frame
        send_frame(8'h16, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        RESET_N = 1'b0;
        #1;
        check("mrst_valid", 16'(EV_VALID),   16'd0);
        check("mrst_count", 16'(EV_COUNT),   16'd0);
        check("mrst_data",  16'(EV_DATA),    16'h000);
        check("mrst_perr",  16'(PARITY_ERR), 16'd0);
        check("mrst_ferr",  16'(FRAME_ERR),  16'd0);
        check("mrst_ovf",   16'(OVERFLOW),   16'd0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);
        send_frame(8'h1E, 1'b0);
        check("mrst_after_count", 16'(EV_COUNT), 16'd1);
        pop_check("mrst_after", 10'h01E);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Parametrised PS/2 keyboard receiver. Replaces ad-hoc shift-register-plus-parity capture with a filtered, frame-checked receiver.
- Decodes E0 (extended) and F0 (break) prefixes into one event word and buffers events in a FIFO with a valid/ready handshake.
- Sits between the board KCLK/KDAT pins and any consumer (LED display, mode logic).
- Reports parity, framing, timeout and overflow conditions.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on KCLK and KDAT (>=2).
- FILTER_LEN, 8, consecutive identical synchronised KCLK samples needed before the filtered clock changes.
- TIMEOUT_CYCLES, 50000, CLK cycles without a filtered KCLK falling edge that abort a frame in progress.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW.

Ports:
- CLK, input, 1, system clock.
- RESET_N, input, 1, asynchronous active-low reset.
- KCLK, input, 1, PS/2 clock pin, asynchronous.
- KDAT, input, 1, PS/2 data pin, asynchronous.
- EV_DATA, output, 10, head event: [9]=break, [8]=extended, [7:0]=scan code.
- EV_VALID, output, 1, FIFO not empty.
- EV_READY, input, 1, consumer accepts the head event when EV_VALID is also high.
- EV_COUNT, output, FIFO_AW+1, number of stored events.
- PARITY_ERR, output, 1, one-cycle pulse when a frame fails the odd-parity check.
- FRAME_ERR, output, 1, one-cycle pulse on a bad stop bit or a timeout.
- OVERFLOW, output, 1, sticky: an event was dropped because the FIFO was full.
- CLR_OVF, input, 1, clears OVERFLOW; has priority over a same-cycle set.

Behaviour:
- Reset (async, RESET_N=0):
  - Synchronisers and the filtered clock go to 1.
  - FSM goes to IDLE; bit counter, timeout counter and prefix flags clear.
  - FIFO empties: EV_VALID=0, EV_COUNT=0, EV_DATA=0.
  - PARITY_ERR=0, FRAME_ERR=0, OVERFLOW=0.
  - Reset mid-frame discards the partial frame.
- Filter:
  - A counter tracks how many cycles the synchronised KCLK has differed from the filtered value.
  - The filtered value flips when the count reaches FILTER_LEN. Any matching sample resets the count.
  - A sample edge is a 1->0 transition of the filtered clock. KDAT is taken from its synchroniser output in that same cycle.
- Frame FSM (advances only on sample edges, except timeout):
  - IDLE: KDAT=0 -> DATA with the bit counter at 0. KDAT=1 -> remain in IDLE, no error.
  - DATA: shift KDAT in LSB-first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: go to IDLE.
    - If KDAT=0, pulse FRAME_ERR and discard the byte.
    - Else, if XOR(data[7:0], parity)=0, pulse PARITY_ERR, discard the byte and clear both prefix flags.
    - Else the byte is good.
- Timeout:
  - In any non-IDLE state the counter increments each cycle and clears on each sample edge.
  - When it reaches TIMEOUT_CYCLES: FSM returns to IDLE, FRAME_ERR pulses, the partial byte is discarded, and the prefix flags are kept.
- Prefix decoder (on each good byte):
  - 0xE0 sets EXT.
  - 0xF0 sets BRK.
  - Any other byte forms the event {BRK, EXT, byte}, then clears both flags.
  - Prefix bytes never produce events.
- Latency: a stop edge detected in cycle t produces the event push at the end of t+1, so EV_VALID rises in cycle t+2 if the FIFO was empty.
- FIFO (first-word-fall-through, registered):
  - Pop occurs when EV_VALID && EV_READY.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Simultaneous push and pop leaves EV_COUNT unchanged.
  - A push while full with no pop drops the new event and sets OVERFLOW; stored events are untouched.
  - Pop while empty is ignored.
  - Pointers wrap modulo depth.
- The error pulses are mutually exclusive per frame. Each is a single cycle wide.

Test Plan:
- Frame 0x1C (parity 0, stop 1) with EV_READY=0 -> EV_VALID=1, EV_DATA=0x01C, EV_COUNT=1; asserting EV_READY one cycle -> EV_COUNT=0, EV_VALID=0.
- Frames F0,1C then E0,F0,75 -> events 0x21C then 0x375; no events for the prefix bytes.
- 0x1C sent with parity 1 -> PARITY_ERR pulses once, no event; a following F0,1C still yields 0x21C.
- Stop after the 4th data bit and wait TIMEOUT_CYCLES -> FRAME_ERR pulse, FSM in IDLE; the next full 0x16 frame -> 0x016.
- EV_READY=0, six make codes 0x16,0x1E,0x26,0x25,0x2E,0x36 -> EV_COUNT=4, OVERFLOW=1, drain order 0x016,0x01E,0x026,0x025; CLR_OVF -> OVERFLOW=0.
- KCLK low glitch of FILTER_LEN-1 cycles in IDLE and mid-frame -> no bit sampled, no error; RESET_N low mid-frame -> all outputs at reset values immediately.
